// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and default sizes for the cache fill controller
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, HIT_RSP, MISS_RSP} state_t;
  localparam int ADDRESSL_DEF  = 15;
  localparam int WORD_DEF      = 16;
  localparam int BLOCKSIZE_DEF = 4;
  localparam int CNTW_DEF      = 15;
endpackage

// File: rtl/cache_fill_controller_sat_counter.sv
// sat_counter: up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  // count up on inc until the counter is full
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (inc && q != {W{1'b1}}) q <= q + 1'b1;
endmodule

// File: rtl/cache_fill_controller.sv
// cache_fill_controller: lookup / block-fill sequencer with hit and miss statistics
module cache_fill_controller
  import cache_pkg::*;
#(
  parameter int ADDRESSL  = ADDRESSL_DEF,
  parameter int BLOCKSIZE = BLOCKSIZE_DEF,
  parameter int CNTW      = CNTW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [ADDRESSL-1:0] address,
  input  logic                hit,
  input  logic                rAck,
  output logic [ADDRESSL-1:0] memAddr,
  output logic                cRead,
  output logic                cWrite,
  output logic                rRead,
  output logic                selOut,
  output logic                ready,
  output logic                busy,
  output logic [CNTW-1:0]     numOfHits,
  output logic [CNTW-1:0]     numOfMisses
);
  localparam int OFFW = $clog2(BLOCKSIZE);
  state_t state, state_nxt;
  logic [ADDRESSL-1:0] addr_reg;
  logic [OFFW-1:0] word_idx;
  logic last;
  assign last = word_idx == OFFW'(BLOCKSIZE - 1);
  // state, captured request address and the fill word index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      addr_reg <= '0;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        addr_reg <= address;
        word_idx <= '0;
      end
      if (state == LOOKUP) word_idx <= '0;
      if (cWrite) word_idx <= word_idx + 1'b1;
    end
  // next state and decoded strobes; the index wraps to zero after the last word
  always_comb begin
    state_nxt = state;
    memAddr   = '0;
    cRead     = 1'b0;
    cWrite    = 1'b0;
    rRead     = 1'b0;
    selOut    = 1'b1;
    ready     = 1'b0;
    case (state)
      IDLE:    state_nxt = req ? LOOKUP : IDLE;
      LOOKUP: begin
        cRead     = 1'b1;
        memAddr   = addr_reg;
        state_nxt = hit ? HIT_RSP : FILL;
      end
      FILL: begin
        rRead     = 1'b1;
        cWrite    = rAck;
        memAddr   = {addr_reg[ADDRESSL-1:OFFW], word_idx};
        state_nxt = (rAck && last) ? MISS_RSP : FILL;
      end
      HIT_RSP: begin
        ready     = 1'b1;
        memAddr   = addr_reg;
        state_nxt = IDLE;
      end
      MISS_RSP: begin
        ready     = 1'b1;
        selOut    = 1'b0;
        cRead     = 1'b1;
        memAddr   = addr_reg;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  sat_counter #(.W(CNTW)) u_hits (.clk(clk), .rst(rst), .inc(state == HIT_RSP), .q(numOfHits));
  sat_counter #(.W(CNTW)) u_misses (.clk(clk), .rst(rst), .inc(state == MISS_RSP), .q(numOfMisses));
endmodule

// File: tb/tb_cache_fill_controller.sv
// tb_cache_fill_controller: randomized transactions checked against a transaction-level model
module tb_cache_fill_controller;
  localparam int AL = 15;
  localparam int BS = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 0, req = 0, hit = 0, rAck = 0;
  logic [AL-1:0] address = '0, memAddr;
  logic cRead, cWrite, rRead, selOut, ready, busy;
  logic [CW-1:0] numOfHits, numOfMisses;
  int checks = 0, passed = 0;
  int m_hits = 0, m_misses = 0;

  cache_fill_controller #(.ADDRESSL(AL), .BLOCKSIZE(BS), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .address(address), .hit(hit), .rAck(rAck),
    .memAddr(memAddr), .cRead(cRead), .cWrite(cWrite), .rRead(rRead), .selOut(selOut),
    .ready(ready), .busy(busy), .numOfHits(numOfHits), .numOfMisses(numOfMisses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_counters();
    chk("num_hits", 32'(numOfHits), 32'(m_hits));
    chk("num_misses", 32'(numOfMisses), 32'(m_misses));
  endtask

  task automatic run_txn(input logic [AL-1:0] a, input logic h, input int ack_pct);
    logic [AL-1:0] base;
    int nw, lat;
    bit got_ready;
    base = a & ~AL'(BS - 1);
    nw = 0;
    lat = -1;
    got_ready = 0;
    @(posedge clk); #1;
    req = 1; address = a; hit = h; rAck = 0;
    @(posedge clk); #1;
    req = 0; address = $urandom;
    for (int c = 0; c < 300 && !got_ready; c++) begin
      rAck = ($urandom_range(99) < ack_pct);
      @(negedge clk);
      if (c == 0) begin
        chk("lookup_cread", cRead, 1);
        chk("lookup_addr", memAddr, a);
      end
      if (rRead) begin
        chk("fill_addr", memAddr, base + AL'(nw));
        chk("fill_cwrite", cWrite, rAck);
        if (cWrite) nw++;
      end else if (c > 0 && !ready) chk("stray_cwrite", cWrite, 0);
      if (ready) begin
        got_ready = 1;
        lat = c;
        chk("rsp_selout", selOut, h);
        chk("rsp_addr", memAddr, a);
      end
      @(posedge clk); #1;
    end
    chk("ready_seen", got_ready, 1);
    chk("fill_words", nw, h ? 0 : BS);
    if (h || ack_pct == 100) chk("latency", lat, h ? 1 : BS + 1);
    if (h) m_hits = m_hits < CMAX ? m_hits + 1 : CMAX;
    else m_misses = m_misses < CMAX ? m_misses + 1 : CMAX;
    chk("idle_after", busy, 0);
    check_counters();
  endtask

  initial begin
    int rdy;
    #2 rst = 1;
    #1;
    chk("rst_memaddr", memAddr, 0);
    chk("rst_strobes", {cRead, cWrite, rRead, ready, busy}, 0);
    chk("rst_selout", selOut, 1);
    check_counters();
    @(negedge clk) rst = 0;
    run_txn(15'h0123, 1, 50);
    run_txn(15'h0126, 0, 100);
    run_txn(15'h0239, 0, 34);
    // abandon a fill on its second word with an asynchronous reset
    @(posedge clk); #1;
    req = 1; address = 15'h0452; hit = 0; rAck = 1;
    @(posedge clk); #1 req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_fill_addr", memAddr, 15'h0451);
    #2 rst = 1;
    #1;
    chk("abort_cwrite", cWrite, 0);
    chk("abort_busy", busy, 0);
    m_hits = 0;
    m_misses = 0;
    check_counters();
    @(negedge clk) rst = 0;
    run_txn(15'h0777, 0, 100);
    for (int i = 0; i < 25; i++) run_txn(AL'($urandom), 1'($urandom), $urandom_range(20, 100));
    // held request: back-to-back hits, one ready every three cycles, counter saturates
    @(posedge clk); #1;
    rst = 1; #1 rst = 0;
    m_hits = 0; m_misses = 0;
    req = 1; hit = 1; rAck = 0; address = 15'h0abc;
    rdy = 0;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (ready) begin
        chk("held_ready_cycle", c % 3, 2);
        chk("held_hits_before", 32'(numOfHits), 32'(m_hits));
        m_hits = m_hits < CMAX ? m_hits + 1 : CMAX;
        rdy++;
      end
      @(posedge clk); #1;
    end
    req = 0;
    chk("held_ready_count", rdy, 9);
    check_counters();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
